line_unpacker: RTL and testbench
================================

Name: line_unpacker

Overview:
- Converts a stream of wide IN-word beats into narrow OUT-word beats. Example: 8-byte memory words read back into 3-byte RGB pixels.
- Line-aware. Each line arrives as a whole number of input beats. Padding words after the last output beat of a line are discarded.
- `out_last_o` marks the final beat of each line.
- Sits between the frame-buffer read path and the pixel pipeline. It is the read-side counterpart of the write-side packer.

Parameters:
- IN, 8, words per input beat
- OUT, 3, words per output beat
- W, 8, bits per word
- LW, 16, width of the line-length port and counters

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous reset, active-high
- line_len_i  input  LW  output beats per line; held stable while a line is in progress
- in_val_i  input  1  input beat valid
- in_data_i  input  W*IN  input beat; word 0 in LSBs
- in_rdy_o  output  1  input ready
- out_val_o  output  1  output beat valid
- out_data_o  output  W*OUT  output beat; word 0 in LSBs
- out_last_o  output  1  qualifies out_val_o; this beat ends the line
- out_rdy_i  input  1  output ready

Behaviour:
- Definitions:
  - push = in_val_i & in_rdy_o
  - pop = out_val_o & out_rdy_i
  - valid/ready protocol; no combinational path from in_val_i to in_rdy_o
- Storage:
  - buffer of BUFF = IN+OUT-1 words, index 0 oldest
  - occupancy v, width $clog2(BUFF+IN+1)
- Counters:
  - ocnt: output beats popped in current line
  - iw: input words accepted in current line, width LW+$clog2(IN*OUT+1)
  - llen: latched line length
- Line start: when ocnt==0 and iw==0, llen <= line_len_i each cycle. line_len_i==0 is treated as 1.
- Derived signals:
  - need = llen*OUT (words the line consumes)
  - in_done = iw >= need
  - eol = pop & (ocnt == llen-1)
- out_val_o = v >= OUT.
- out_data_o = buffer[0..OUT-1] (registered, zero latency from storage).
- out_last_o = out_val_o & (ocnt == llen-1).
- in_rdy_o (may depend combinationally on out_rdy_i):
  - if eol: 1
  - else if in_done: 0 (next-line data must never sit behind padding)
  - else if pop: v-OUT+IN <= BUFF
  - else: v+IN <= BUFF
- Buffer update:
  - pop only, non-eol: shift down by OUT.
  - push only: write IN words at index v.
  - pop and push, non-eol: shift down by OUT and write at v-OUT.
  - eol: discard all remaining words (padding, v-OUT < IN).
    - If push in the same cycle, new beat lands at index 0 and v <= IN; else v <= 0.
    - ocnt <= 0.
    - iw <= (push ? IN : 0).
    - llen re-latched from line_len_i on the following idle cycle. If push occurs on the eol cycle, llen <= line_len_i on that cycle.
- Non-eol counter updates: ocnt += pop; iw += push ? IN : 0.
- Unused/discarded buffer slots are zeroed.
- Precondition: the input supplies exactly ceil(need/IN) beats per line. Padding never exceeds IN-1 words.
- Reset (rst_i=1 at clock edge): v, ocnt, iw, buffer = 0; llen = 1.
  - Outputs then: out_val_o=0, out_last_o=0, out_data_o=0, in_rdy_o=1.
  - Reset mid-line abandons the line. Next accepted beat starts a new line.
- Latency: first output beat valid one cycle after the push that makes v >= OUT.

Decomposition:
- Shared package: the pixel/word width constant W=8 and the 3-word/8-word beat constants, reused by the write-side packer.
- One natural sub-module, `unpack_buffer`: the shift/insert storage with push, pop, and a `clear_on_pop` input. Line/counter control stays in `line_unpacker`.

Test Plan (IN=8, OUT=3, W=8):
- Basic line, line_len=5, input words 0..15 in two beats, out_rdy_i=1:
  - outputs {2,1,0}, {5,4,3}, {8,7,6}, {11,10,9}, {14,13,12}; last beat has out_last_o=1.
  - word 15 never emitted.
  - in_rdy_o=0 after the second push until the eol pop.
- Back-to-back lines, line_len=5: beat 0 of line 2 (words 100..107) presented during line 1's last beat.
  - Accepted on the eol cycle.
  - Next output {102,101,100}, no padding leakage.
- Exact fit, line_len=8 (24 words, 3 beats):
  - 8 outputs, last on 8th; nothing dropped.
  - v=0 after eol with no push.
- Backpressure: out_rdy_i toggled 1/0 each cycle.
  - Data order identical to scenario 1.
  - in_rdy_o never 1 when v+IN > BUFF without a pop.
- Reset mid-line: rst_i after 2 output beats of a line_len=5 line.
  - Next cycle: out_val_o=0, in_rdy_o=1.
  - A fresh line_len=1 line with words 0..7 gives single beat {2,1,0} with out_last_o=1.
- line_len_i=0: behaves as line_len=1; every output beat has out_last_o=1.

Source files
------------

// File: rtl/line_unpacker_pkg.sv
// Shared beat/word geometry for the frame-buffer packer and unpacker.
// Exposes word width, beat sizes and the unpacker storage depth helper.
package line_unpacker_pkg;

    localparam int unsigned PX_W     = 8;
    localparam int unsigned BEAT_IN  = 8;
    localparam int unsigned BEAT_OUT = 3;

    // Deepest leftover (OUT-1) plus one fresh input beat.
    function automatic int unsigned buff_words(int unsigned in_w,
                                               int unsigned out_w);
        return in_w + out_w - 1;
    endfunction

endpackage

// File: rtl/line_unpacker_buffer.sv
// Shift/insert word store for the line unpacker.
// Ports: clk_i/rst_i, push_i+in_data_i write IN words at the tail,
// pop_i drops OUT words from the head (or everything when
// clear_on_pop_i), occ_o is the word count, head_o the oldest OUT words.
module unpack_buffer
    import line_unpacker_pkg::*;
#(
    parameter int unsigned IN  = BEAT_IN,
    parameter int unsigned OUT = BEAT_OUT,
    parameter int unsigned W   = PX_W,
    parameter int unsigned VW  = $clog2(buff_words(IN, OUT) + IN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_on_pop_i,
    input  logic [W*IN-1:0] in_data_i,
    output logic [VW-1:0]   occ_o,
    output logic [W*OUT-1:0] head_o
);

    localparam int unsigned BUFF = buff_words(IN, OUT);

    logic [W-1:0]  mem_q [BUFF];
    logic [W-1:0]  mem_d [BUFF];
    logic [W-1:0]  mem_x [BUFF+IN];
    logic [VW-1:0] occ_q, occ_d, base;

    always_comb begin
        for (int i = 0; i < BUFF + IN; i++) mem_x[i] = '0;
        for (int i = 0; i < BUFF; i++) mem_x[i] = mem_q[i];
        base = occ_q;
        if (pop_i) begin
            if (clear_on_pop_i) begin
                for (int i = 0; i < BUFF + IN; i++) mem_x[i] = '0;
                base = '0;
            end else begin
                for (int i = 0; i < BUFF - OUT; i++) mem_x[i] = mem_q[i+OUT];
                for (int i = BUFF - OUT; i < BUFF + IN; i++) mem_x[i] = '0;
                base = occ_q - VW'(OUT);
            end
        end
        if (push_i) begin
            for (int j = 0; j < IN; j++)
                mem_x[base + VW'(j)] = in_data_i[j*W +: W];
        end
        occ_d = push_i ? base + VW'(IN) : base;
        for (int i = 0; i < BUFF; i++) mem_d[i] = mem_x[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
            for (int i = 0; i < BUFF; i++) mem_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < BUFF; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        for (int k = 0; k < OUT; k++) head_o[k*W +: W] = mem_q[k];
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/line_unpacker.sv
// Line-aware wide-to-narrow beat unpacker; drops per-line padding.
// Ports: clk_i/rst_i, line_len_i, in_* (valid/ready wide beat),
// out_* (valid/ready narrow beat, out_last_o ends the line).
module line_unpacker
    import line_unpacker_pkg::*;
#(
    parameter int unsigned IN  = BEAT_IN,
    parameter int unsigned OUT = BEAT_OUT,
    parameter int unsigned W   = PX_W,
    parameter int unsigned LW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LW-1:0]    line_len_i,
    input  logic             in_val_i,
    input  logic [W*IN-1:0]  in_data_i,
    output logic             in_rdy_o,
    output logic             out_val_o,
    output logic [W*OUT-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             out_rdy_i
);

    localparam int unsigned BUFF = buff_words(IN, OUT);
    localparam int unsigned VW   = $clog2(BUFF + IN + 1);
    localparam int unsigned IWW  = LW + $clog2(IN * OUT + 1);

    logic [VW-1:0]  occ;
    logic [LW-1:0]  ocnt_q, ocnt_d, llen_q, llen_d, len_eff;
    logic [IWW-1:0] iw_q, iw_d, need;
    logic           push, pop, eol, last_beat, in_done;

    assign len_eff   = (line_len_i == '0) ? LW'(1) : line_len_i;
    assign need      = IWW'(llen_q) * IWW'(OUT);
    assign in_done   = iw_q >= need;
    assign last_beat = ocnt_q == llen_q - LW'(1);

    assign out_val_o  = occ >= VW'(OUT);
    assign out_last_o = out_val_o & last_beat;
    assign pop        = out_val_o & out_rdy_i;
    assign eol        = pop & last_beat;
    assign push       = in_val_i & in_rdy_o;

    // Once the line is fully fetched, hold input off until the eol pop
    // so next-line words never queue behind padding.
    always_comb begin
        if (eol)
            in_rdy_o = 1'b1;
        else if (in_done)
            in_rdy_o = 1'b0;
        else if (pop)
            in_rdy_o = occ - VW'(OUT) + VW'(IN) <= VW'(BUFF);
        else
            in_rdy_o = occ + VW'(IN) <= VW'(BUFF);
    end

    always_comb begin
        ocnt_d = ocnt_q;
        iw_d   = iw_q;
        llen_d = llen_q;
        if (eol) begin
            ocnt_d = '0;
            iw_d   = push ? IWW'(IN) : '0;
            if (push) llen_d = len_eff;
        end else begin
            if (pop)  ocnt_d = ocnt_q + LW'(1);
            if (push) iw_d   = iw_q + IWW'(IN);
            if (ocnt_q == '0 && iw_q == '0) llen_d = len_eff;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ocnt_q <= '0;
            iw_q   <= '0;
            llen_q <= LW'(1);
        end else begin
            ocnt_q <= ocnt_d;
            iw_q   <= iw_d;
            llen_q <= llen_d;
        end
    end

    unpack_buffer #(
        .IN (IN),
        .OUT(OUT),
        .W  (W),
        .VW (VW)
    ) u_buf (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (push),
        .pop_i         (pop),
        .clear_on_pop_i(last_beat),
        .in_data_i     (in_data_i),
        .occ_o         (occ),
        .head_o        (out_data_o)
    );

endmodule

// File: tb/tb_line_unpacker.sv
// Directed bench for line_unpacker (IN=8, OUT=3, W=8).
// Hand-built beats/expected pixels plus a tiny occupancy model.
module tb_line_unpacker;

    logic        clk_i = 0;
    logic        rst_i;
    logic [15:0] line_len_i;
    logic        in_val_i;
    logic [63:0] in_data_i;
    logic        in_rdy_o;
    logic        out_val_o;
    logic [23:0] out_data_o;
    logic        out_last_o;
    logic        out_rdy_i;

    int checks = 0;
    int fails  = 0;

    logic [63:0] beats_q[$];
    logic [24:0] exp_q[$];

    line_unpacker dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .line_len_i(line_len_i),
        .in_val_i  (in_val_i),
        .in_data_i (in_data_i),
        .in_rdy_o  (in_rdy_o),
        .out_val_o (out_val_o),
        .out_data_o(out_data_o),
        .out_last_o(out_last_o),
        .out_rdy_i (out_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat_of(input int s);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) b[i*8 +: 8] = 8'(s + i);
        return b;
    endfunction

    function automatic logic [24:0] px(input int s, input bit last);
        return {last, 8'(s + 2), 8'(s + 1), 8'(s)};
    endfunction

    // Drives beats_q, checks pops against exp_q; model tracks words
    // held (mv) and words fetched in the current line (mi).
    task automatic run(input int len, input bit bp, input int max_out);
        int bi = 0, oi = 0, mi = 0, mv = 0, cyc = 0, need;
        bit done = 0, pop, push, eolm;
        int nb = beats_q.size();
        int ne = exp_q.size();
        line_len_i = 16'(len);
        need = ((len == 0) ? 1 : len) * 3;
        while (!done && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            out_rdy_i = bp ? cyc[0] : 1'b1;
            in_val_i  = bi < nb;
            in_data_i = (bi < nb) ? beats_q[bi] : '0;
            #1;
            chk("val", out_val_o, mv >= 3);
            pop  = out_val_o && out_rdy_i;
            push = in_val_i && in_rdy_o;
            eolm = 0;
            if (pop) begin
                if (oi < ne) begin
                    chk("data", out_data_o, exp_q[oi][23:0]);
                    chk("last", out_last_o, exp_q[oi][24]);
                    eolm = exp_q[oi][24];
                end else begin
                    chk("extra", oi, ne);
                end
                oi++;
            end
            if (bp) chk("rdy_cap", in_rdy_o && !pop && (mv + 8 > 10), 0);
            if (mi >= need && !eolm) chk("rdy_done", in_rdy_o, 0);
            if (eolm && bi < nb) chk("eol_push", in_rdy_o, 1);
            if (eolm) begin
                mv = push ? 8 : 0;
                mi = push ? 8 : 0;
            end else begin
                mv = mv - (pop ? 3 : 0) + (push ? 8 : 0);
                mi = mi + (push ? 8 : 0);
            end
            if (push) bi++;
            if (oi >= max_out || (oi == ne && bi == nb)) done = 1;
        end
        chk("count", oi, (max_out < ne) ? max_out : ne);
        @(negedge clk_i);
        in_val_i  = 0;
        out_rdy_i = 1;
        if (max_out >= ne) begin
            #1;
            chk("idle_val", out_val_o, 0);
            chk("idle_rdy", in_rdy_o, 1);
        end
    endtask

    initial begin
        rst_i = 1; line_len_i = 5; in_val_i = 0;
        in_data_i = 0; out_rdy_i = 1;
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        #1;
        chk("rst_val", out_val_o, 0);
        chk("rst_last", out_last_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_rdy", in_rdy_o, 1);

        // basic line, word 15 is padding
        beats_q = {beat_of(0), beat_of(8)};
        exp_q = {px(0,0), px(3,0), px(6,0), px(9,0), px(12,1)};
        run(5, 0, 99);

        // back-to-back lines, next beat taken on eol
        beats_q = {beat_of(0), beat_of(8), beat_of(100), beat_of(108)};
        exp_q = {px(0,0), px(3,0), px(6,0), px(9,0), px(12,1),
                 px(100,0), px(103,0), px(106,0), px(109,0), px(112,1)};
        run(5, 0, 99);

        // exact fit: 24 words, no padding
        beats_q = {beat_of(0), beat_of(8), beat_of(16)};
        exp_q = {px(0,0), px(3,0), px(6,0), px(9,0),
                 px(12,0), px(15,0), px(18,0), px(21,1)};
        run(8, 0, 99);

        // backpressure
        beats_q = {beat_of(0), beat_of(8)};
        exp_q = {px(0,0), px(3,0), px(6,0), px(9,0), px(12,1)};
        run(5, 1, 99);

        // reset after two pixels of a line
        beats_q = {beat_of(0), beat_of(8)};
        exp_q = {px(0,0), px(3,0), px(6,0), px(9,0), px(12,1)};
        run(5, 0, 2);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        #1;
        chk("mid_rst_val", out_val_o, 0);
        chk("mid_rst_rdy", in_rdy_o, 1);
        beats_q = {beat_of(0)};
        exp_q = {px(0,1)};
        run(1, 0, 99);

        // zero length acts as one
        beats_q = {beat_of(0), beat_of(8)};
        exp_q = {px(0,1), px(8,1)};
        run(0, 0, 99);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
